fifo_share_ctrl: RTL and testbench
==================================

Name: fifo_share_ctrl

Overview:
Controller that shares one single-clock FIFO (fifo_sc IP: Data/WrEn/RdEn/Q/Empty/Full) between two write requesters and drains it in bursts towards one downstream consumer. A round-robin arbiter grants one write per cycle. A read sequencer issues RdEn, captures Q, and presents it on a valid/ready output. An internal occupancy counter mirrors the FIFO level so bursts start only when enough data is stored.

Parameters:
DW, 8, data width (matches FIFO Data/Q)
DEPTH, 16, FIFO depth in words
AW, 4, log2(DEPTH)
BURST, 4, words per read burst (1..DEPTH)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has a word
req0_data  in  DW  requester 0 word
req0_ready  out  1  requester 0 word accepted this cycle
req1_valid  in  1  requester 1 has a word
req1_data  in  DW  requester 1 word
req1_ready  out  1  requester 1 word accepted this cycle
flush  in  1  pulse: drain remaining words even if level < BURST
fifo_data  out  DW  to FIFO Data
fifo_wren  out  1  to FIFO WrEn
fifo_rden  out  1  to FIFO RdEn
fifo_q  in  DW  from FIFO Q (valid 1 cycle after RdEn)
fifo_empty  in  1  from FIFO Empty
fifo_full  in  1  from FIFO Full
out_valid  out  1  out_data holds a word
out_data  out  DW  drained word
out_ready  in  1  consumer accepts word
level  out  AW+1  words currently stored (0..DEPTH)
busy  out  1  read sequencer not in IDLE

Behaviour:
- Reset (rst_n low, async): level=0, out_valid=0, out_data=0, fifo_rden=0, busy=0, FSM=IDLE, RR pointer=0 (req0 favoured first), flush_pend=0. Outputs fifo_wren/reqN_ready=0 while in reset.
- Write arbiter (combinational grant, registered pointer): can_wr = ~fifo_full & (level != DEPTH). Only one valid -> that one granted. Both valid -> requester at RR pointer granted. reqN_ready = grant_N & can_wr. fifo_wren = OR of reqN_ready; fifo_data = granted data (0 when idle). Pointer toggles to the other requester after every accepted write from the favoured one; unchanged when nothing accepted.
- Level: +1 on wren & ~rden, -1 on rden & ~wren, unchanged on both/neither. Never exceeds DEPTH, never below 0.
- flush pulse sets flush_pend; cleared when a burst starts or level==0.
- Read FSM: IDLE, RD, CAP, HOLD.
  IDLE: if level>=BURST, or flush_pend & level>0: load remaining=min(level,BURST), go RD.
  RD: fifo_rden=1 (one cycle only), remaining-1, go CAP.
  CAP: capture fifo_q into out_data, set out_valid, go HOLD.
  HOLD: when out_valid & out_ready: clear out_valid; remaining>0 -> RD, else IDLE.
- Latency: rden to out_valid = 2 cycles; max throughput 1 word / 3 cycles with out_ready held high.
- out_data stable while out_valid & ~out_ready.
- Guard: rden never asserted when level==0 or fifo_empty=1; if fifo_empty seen in RD, FSM returns to IDLE without rden.
- Simultaneous write and read in the same cycle is legal; level unchanged.
- Reset mid-burst: all state cleared immediately; FIFO contents are not the controller's concern (FIFO Reset driven separately).

Decomposition:
- Package fifo_share_pkg: FSM state enum (IDLE, RD, CAP, HOLD), default DW/DEPTH/BURST constants.
- Sub-module rr_arb2: two-input round-robin arbiter (valid in, grant out, accept in for pointer update). Remainder in top.

Test Plan:
- Reset: rst_n low mid-run -> level=0, out_valid=0, fifo_rden=0 within same cycle (async), busy=0.
- Single writer: req0 sends 0x10..0x13 back-to-back -> four wrens, level=4, burst fires, out_data 0x10,0x11,0x12,0x13 in order, level returns to 0.
- Contention: both valid continuously, req0 data 0xA0.., req1 0xB0.. -> FIFO order A0,B0,A1,B1..., each readyN asserted every other cycle.
- Full: writers push 20 words with out_ready=0 -> level saturates at 16, reqN_ready=0 while full, no word lost, drained order intact.
- Flush: write 2 words (<BURST), pulse flush -> exactly 2 rdens, 2 output words, FSM to IDLE, level=0.
- Backpressure: out_ready low 5 cycles during HOLD -> out_data/out_valid stable, no extra rden, resumes on out_ready.

Source files
------------

// File: rtl/fifo_share_pkg.sv
// Shared types and defaults for the shared-FIFO write/drain controller.
// Contents: read sequencer state enum, default data width / depth / burst.
package fifo_share_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      CAP  = 2'd2,
      HOLD = 2'd3
   } rd_state_t;

   localparam int DW_DEF    = 8;
   localparam int DEPTH_DEF = 16;
   localparam int AW_DEF    = 4;
   localparam int BURST_DEF = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   valid[1:0] : request lines (bit 0 = requester 0)
//   accept     : the granted request is taken this cycle
//   grant[1:0] : one-hot grant (combinational)
module rr_arb2
   import fifo_share_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       accept,
   output logic [1:0] grant
);

   // ptr names the requester that wins a tie
   logic ptr;

   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = ptr ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   // Only a write taken from the favoured side hands the tie to the other one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= 1'b0;
      end else if (accept && grant[ptr]) begin
         ptr <= ~ptr;
      end
   end

endmodule

// File: rtl/fifo_share_ctrl.sv
// Shares one single-clock FIFO between two writers and drains it in bursts
// to a valid/ready consumer. An internal level counter mirrors the FIFO fill.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for level >= BURST, or a pending flush with data
// RD    | issue one RdEn (skipped if FIFO reports empty)
// CAP   | FIFO Q valid, capture into out_data, raise out_valid
// HOLD  | wait for consumer handshake, then next word or IDLE
//
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   reqN_valid/reqN_data/reqN_ready: writer handshakes (N = 0, 1)
//   flush                          : drain remaining words below BURST
//   fifo_data/fifo_wren/fifo_rden  : to FIFO
//   fifo_q/fifo_empty/fifo_full    : from FIFO
//   out_valid/out_data/out_ready   : drained word to consumer
//   level                          : words currently stored
//   busy                           : read sequencer active
module fifo_share_ctrl
   import fifo_share_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF,
   parameter int BURST = BURST_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0_valid,
   input  logic [DW-1:0] req0_data,
   output logic          req0_ready,
   input  logic          req1_valid,
   input  logic [DW-1:0] req1_data,
   output logic          req1_ready,
   input  logic          flush,
   output logic [DW-1:0] fifo_data,
   output logic          fifo_wren,
   output logic          fifo_rden,
   input  logic [DW-1:0] fifo_q,
   input  logic          fifo_empty,
   input  logic          fifo_full,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic [AW:0]   level,
   output logic          busy
);

   localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];
   localparam logic [AW:0] BURST_L = BURST[AW:0];

   rd_state_t   state, state_nxt;
   logic [AW:0] remaining;
   logic        flush_pend;
   logic        burst_start;
   logic        can_wr;
   logic [1:0]  grant;

   // Write side
   assign can_wr = ~fifo_full & (level != DEPTH_L);

   rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid  ({req1_valid, req0_valid}),
      .accept (can_wr & rst_n),
      .grant  (grant)
   );

   // Gated by rst_n so no write leaks into the FIFO while held in reset.
   assign req0_ready = rst_n & can_wr & grant[0];
   assign req1_ready = rst_n & can_wr & grant[1];
   assign fifo_wren  = req0_ready | req1_ready;
   assign fifo_data  = req0_ready ? req0_data :
                       req1_ready ? req1_data : '0;

   // Read sequencer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      fifo_rden   = 1'b0;
      burst_start = 1'b0;
      case (state)
         IDLE: begin
            if ((level >= BURST_L) || (flush_pend && (level != '0))) begin
               burst_start = 1'b1;
               state_nxt   = RD;
            end
         end
         RD: begin
            if (fifo_empty || (level == '0)) begin
               state_nxt = IDLE;
            end else begin
               fifo_rden = 1'b1;
               state_nxt = CAP;
            end
         end
         CAP: state_nxt = HOLD;
         HOLD: begin
            if (out_valid && out_ready) begin
               state_nxt = (remaining != '0) ? RD : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // Datapath: burst down-counter, output register, level mirror, flush latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining  <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         level      <= '0;
         flush_pend <= 1'b0;
      end else begin
         if (burst_start) begin
            remaining <= (level < BURST_L) ? level : BURST_L;
         end else if (fifo_rden) begin
            remaining <= remaining - 1'b1;
         end

         if (state == CAP) begin
            out_data  <= fifo_q;
            out_valid <= 1'b1;
         end else if ((state == HOLD) && out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         case ({fifo_wren, fifo_rden})
            2'b10: if (level != DEPTH_L) level <= level + 1'b1;
            2'b01: if (level != '0)      level <= level - 1'b1;
            default: ;
         endcase

         // Clearing wins so a flush seen at level 0 does not linger.
         if (burst_start || (level == '0)) begin
            flush_pend <= 1'b0;
         end else if (flush) begin
            flush_pend <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_share_ctrl.sv
module tb_fifo_share_ctrl;

   logic       clk;
   logic       rst_n;
   logic       req0_valid, req1_valid;
   logic [7:0] req0_data, req1_data;
   logic       req0_ready, req1_ready;
   logic       flush;
   logic [7:0] fifo_data;
   logic       fifo_wren, fifo_rden;
   logic [7:0] fifo_q;
   logic       fifo_empty, fifo_full;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic [4:0] level;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   fifo_share_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .flush      (flush),
      .fifo_data  (fifo_data),
      .fifo_wren  (fifo_wren),
      .fifo_rden  (fifo_rden),
      .fifo_q     (fifo_q),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .level      (level),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-clock FIFO, Q registered one cycle after RdEn
   logic [7:0] mem [16];
   logic [3:0] wp, rp;
   logic [4:0] cnt;

   assign fifo_empty = (cnt == 5'd0);
   assign fifo_full  = (cnt == 5'd16);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp     <= '0;
         rp     <= '0;
         cnt    <= '0;
         fifo_q <= '0;
      end else begin
         if (fifo_wren && cnt < 5'd16) begin
            mem[wp] <= fifo_data;
            wp      <= wp + 4'd1;
         end
         if (fifo_rden && cnt != 5'd0) begin
            fifo_q <= mem[rp];
            rp     <= rp + 4'd1;
         end
         cnt <= cnt + 5'(fifo_wren && cnt < 5'd16) - 5'(fifo_rden && cnt != 5'd0);
      end
   end

   // Consumer-side monitor
   logic [7:0] got [$];
   int         rden_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         got.delete();
         rden_cnt <= 0;
      end else begin
         if (out_valid && out_ready) got.push_back(out_data);
         if (fifo_rden) rden_cnt <= rden_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_data  = '0;
      req1_data  = '0;
      flush      = 1'b0;
      out_ready  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic write0(input logic [7:0] d, input string tag);
      req0_valid = 1'b1;
      req0_data  = d;
      #1 chk(tag, req0_ready, 1);
      @(negedge clk);
      req0_valid = 1'b0;
   endtask

   task automatic wait_drain(input int n, input string tag);
      int cyc = 0;
      while (!(got.size() >= n && !busy && level == 5'd0) && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_done"}, 32'(cyc < 300), 1);
   endtask

   function automatic logic [7:0] got_at(input int i);
      return (i < got.size()) ? got[i] : 8'hxx;
   endfunction

   int n0, n1, n, cyc;

   initial begin
      // Reset state, writes blocked while in reset
      rst_n      = 1'b0;
      req0_valid = 1'b1;
      req0_data  = 8'h55;
      req1_valid = 1'b0;
      req1_data  = '0;
      flush      = 1'b0;
      out_ready  = 1'b0;
      @(negedge clk);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_wren", fifo_wren, 0);
      chk("rst_level", level, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rden", fifo_rden, 0);
      chk("rst_out_data", out_data, 0);
      do_reset();

      // Single writer, one burst
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req0_valid = 1'b1;
         req0_data  = 8'h10 + 8'(i);
         #1 chk("single_ready", req0_ready, 1);
         chk("single_wren", fifo_wren, 1);
         @(negedge clk);
      end
      req0_valid = 1'b0;
      chk("single_level4", level, 4);
      chk("single_idle", busy, 0);
      wait_drain(4, "single");
      for (int i = 0; i < 4; i++) chk("single_word", got_at(i), 32'h10 + i);
      chk("single_rdens", rden_cnt, 4);

      // Contention: strict alternation starting with req0
      do_reset();
      out_ready = 1'b1;
      n0 = 0;
      n1 = 0;
      for (int k = 0; k < 8; k++) begin
         req0_valid = 1'b1;
         req1_valid = 1'b1;
         req0_data  = 8'hA0 + 8'(n0);
         req1_data  = 8'hB0 + 8'(n1);
         #1 chk("cont_ready0", req0_ready, 32'(k % 2 == 0));
         chk("cont_ready1", req1_ready, 32'(k % 2 == 1));
         if (req0_ready) n0++;
         if (req1_ready) n1++;
         @(negedge clk);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_drain(8, "cont");
      for (int i = 0; i < 8; i++)
         chk("cont_word", got_at(i), (i % 2 == 0) ? 32'hA0 + i / 2 : 32'hB0 + i / 2);

      // Full: 17 accepted (16 stored + 1 held in out_data), then drain all 20
      do_reset();
      out_ready = 1'b0;
      n = 0;
      for (int k = 0; k < 22; k++) begin
         req0_valid = 1'b1;
         req0_data  = 8'h40 + 8'(n);
         #1 if (req0_ready) n++;
         @(negedge clk);
      end
      req0_data = 8'h40 + 8'(n);
      #1;
      chk("full_accepted", n, 17);
      chk("full_level", level, 16);
      chk("full_ready_low", req0_ready, 0);
      chk("full_fifo_full", fifo_full, 1);
      chk("full_held_word", out_data, 8'h40);
      @(negedge clk);
      out_ready = 1'b1;
      cyc = 0;
      while (n < 20 && cyc < 200) begin
         req0_valid = 1'b1;
         req0_data  = 8'h40 + 8'(n);
         #1 if (req0_ready) n++;
         @(negedge clk);
         cyc++;
      end
      req0_valid = 1'b0;
      chk("full_all_taken", n, 20);
      wait_drain(20, "full");
      for (int i = 0; i < 20; i++) chk("full_word", got_at(i), 32'h40 + i);

      // Flush below burst size
      do_reset();
      out_ready = 1'b1;
      write0(8'h20, "flush_wr");
      write0(8'h21, "flush_wr");
      repeat (3) @(negedge clk);
      chk("flush_wait_idle", busy, 0);
      chk("flush_wait_level", level, 2);
      chk("flush_no_rden", rden_cnt, 0);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      wait_drain(2, "flush");
      chk("flush_rdens", rden_cnt, 2);
      chk("flush_word0", got_at(0), 8'h20);
      chk("flush_word1", got_at(1), 8'h21);
      chk("flush_count", got.size(), 2);

      // Latency and backpressure
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) write0(8'h30 + 8'(i), "bp_wr");
      cyc = 0;
      while (!fifo_rden && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("bp_rden_seen", fifo_rden, 1);
      @(negedge clk);
      chk("lat_cap", out_valid, 0);
      @(negedge clk);
      chk("lat_valid", out_valid, 1);
      chk("lat_data", out_data, 8'h30);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", out_valid, 1);
         chk("bp_data", out_data, 8'h30);
         chk("bp_rdens", rden_cnt, 1);
      end
      out_ready = 1'b1;
      wait_drain(4, "bp");
      for (int i = 0; i < 4; i++) chk("bp_word", got_at(i), 32'h30 + i);
      chk("bp_total_rdens", rden_cnt, 4);

      // Asynchronous reset mid-burst
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) write0(8'h60 + 8'(i), "mid_wr");
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("mid_valid_seen", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_level", level, 0);
      chk("mid_out_valid", out_valid, 0);
      chk("mid_busy", busy, 0);
      chk("mid_rden", fifo_rden, 0);
      chk("mid_out_data", out_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
